// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter register plus multi-beat instruction fetch sequencer.
//   A start in IDLE freezes the fetch address and issues BEATS consecutive
//   memory beats. Each beat holds its address until the memory acknowledges
//   it. The assembled instruction is published in the DONE cycle, and the PC
//   then advances by BEATS or takes a branch/jump target.
//
//   Optional feature macro: FETCH_ALIGN_CHECK_EN
//     defined   : a pc_load with nonzero low BB bits is aligned down and sets
//                 the sticky misalign flag. An aligned pc_load clears the flag.
//     undefined : pc_next is loaded unmodified and misalign is tied to 0.
//
// Ports
//   clk          sole clock, rising edge
//   rstb         asynchronous active-low reset
//   start        fetch request (only looked at in IDLE)
//   pc_load      load PC from pc_next
//   pc_next      [AWIDTH] load value
//   mem_rdata    [DWIDTH] read data for the current beat
//   mem_valid    beat acknowledge
//   mem_req      beat request (high for every FETCH cycle)
//   mem_addr     [AWIDTH] beat address {fetch_pc[AWIDTH-1:BB], beat}
//   instr        [IWIDTH] last completed instruction
//   instr_valid  high for the single DONE cycle
//   busy         high in FETCH and DONE
//   pc           [AWIDTH] current PC register
//   misalign     sticky misaligned-load flag
module pc_fetch_unit #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8,
  parameter int IWIDTH = 32,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              pc_load,
  input  logic [AWIDTH-1:0] pc_next,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              mem_req,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [IWIDTH-1:0] instr,
  output logic              instr_valid,
  output logic              busy,
  output logic [AWIDTH-1:0] pc,
  output logic              misalign
);

  localparam int BEATS = IWIDTH / DWIDTH;
  localparam int BB    = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t                         state_q, state_d;
  logic [BB-1:0]                  beat_q;
  logic [AWIDTH-BB-1:0]           fpc_q;      // frozen fetch_pc, upper bits only
  logic [AWIDTH-1:0]              pc_q;
  logic [AWIDTH-1:0]              pend_q;     // pending branch target
  logic                           pend_vld_q;
  logic [AWIDTH-1:0]              ld_val;     // pc_next after optional alignment
  logic [BEATS-1:0][DWIDTH-1:0]   buf_q, buf_nxt;
  logic [IWIDTH-1:0]              instr_q;
  logic                           accept, last_beat;

  // A beat is taken only while requesting. A stray mem_valid is ignored.
  assign accept    = mem_req & mem_valid;
  assign last_beat = accept && (beat_q == {BB{1'b1}});

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign ld_val = {pc_next[AWIDTH-1:BB], {BB{1'b0}}};

  // The flag is sticky across loads until an aligned load or reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)        misalign_q <= 1'b0;
    else if (pc_load) misalign_q <= |pc_next[BB-1:0];
  end

  assign misalign = misalign_q;
`else
  assign ld_val   = pc_next;
  assign misalign = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)     state_d = FETCH;
      FETCH:   if (last_beat) state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // These are decoded from the state so that an async reset drops them at once.
  always_comb begin
    mem_req     = 1'b0;
    busy        = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        busy    = 1'b1;
      end
      DONE: begin
        busy        = 1'b1;
        instr_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- beat counter / fetch address ----------------
  // A same-cycle pc_load redirects the fetch that is starting.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      beat_q <= '0;
      fpc_q  <= '0;
    end else if (state_q == IDLE && start) begin
      beat_q <= '0;
      fpc_q  <= pc_load ? ld_val[AWIDTH-1:BB] : pc_q[AWIDTH-1:BB];
    end else if (accept) begin
      beat_q <= beat_q + 1'b1;
    end
  end

  assign mem_addr = {fpc_q, beat_q};

  // ---------------- beat assembly, one lane per beat ----------------
  for (genvar g = 0; g < BEATS; g++) begin : g_lane
    assign buf_nxt[g] = (accept && beat_q == BB'(g)) ? mem_rdata : buf_q[g];
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) buf_q <= '0;
    else       buf_q <= buf_nxt;
  end

  // Capture through buf_nxt so that the final beat lands on the DONE-entry edge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)          instr_q <= '0;
    else if (last_beat) instr_q <= buf_nxt;
  end

  assign instr = instr_q;

  // ---------------- PC register and pending load ----------------
  // During FETCH a load only becomes pending, and the newest load wins.
  // On DONE entry a load takes priority over the increment. A load seen
  // in the same cycle counts as the newest pending value.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (pc_load) pc_q <= ld_val;
        FETCH: begin
          if (last_beat) begin
            pc_q       <= pc_load    ? ld_val :
                          pend_vld_q ? pend_q : pc_q + AWIDTH'(BEATS);
            pend_vld_q <= 1'b0;
          end else if (pc_load) begin
            pend_q     <= ld_val;
            pend_vld_q <= 1'b1;
          end
        end
        DONE: begin
          if (pc_load)         pc_q <= ld_val;
          else if (pend_vld_q) pc_q <= pend_q;
          pend_vld_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit (default parameters: 8-bit address,
// 8-bit beats, 32-bit instruction, 4 beats). Every expected value below
// is worked out by hand from the intended behaviour.
module tb_pc_fetch_unit;

  logic        clk, rstb, start, pc_load, mem_valid;
  logic [7:0]  pc_next, mem_rdata;
  logic        mem_req, instr_valid, busy, misalign;
  logic [7:0]  mem_addr, pc;
  logic [31:0] instr;

  int ncmp  = 0;
  int nfail = 0;

  pc_fetch_unit dut (
    .clk         (clk),
    .rstb        (rstb),
    .start       (start),
    .pc_load     (pc_load),
    .pc_next     (pc_next),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .busy        (busy),
    .pc          (pc),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue start, then serve BEATS beats. The task can hold mem_valid low
  // before one beat and assert pc_load during one beat. It returns in
  // the DONE cycle.
  task automatic do_fetch(input logic [7:0] base, input logic [31:0] word,
                          input int stall_beat, input int stall_n,
                          input int load_beat, input logic [7:0] load_val,
                          input logic [7:0] pc_hold, input logic [7:0] exp_pc);
    int cyc;
    logic [7:0] a;
    start = 1'b1;
    tick();
    start   = 1'b0;
    pc_load = 1'b0;
    cyc     = 1;
    for (int b = 0; b < 4; b++) begin
      a = base + 8'(b);
      if (b == stall_beat) begin
        mem_valid = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk("stall_req", mem_req, 1);
          chk("stall_addr", mem_addr, a);
          tick();
          cyc++;
        end
        mem_valid = 1'b1;
      end
      chk("mem_req", mem_req, 1);
      chk("mem_addr", mem_addr, a);
      chk("pc_hold", pc, pc_hold);
      if (b == load_beat) begin
        pc_load = 1'b1;
        pc_next = load_val;
      end
      mem_rdata = word[b*8 +: 8];
      tick();
      cyc++;
      pc_load = 1'b0;
    end
    chk("instr_valid", instr_valid, 1);
    chk("instr", instr, word);
    chk("done_req", mem_req, 0);
    chk("done_busy", busy, 1);
    chk("pc_after", pc, exp_pc);
    chk("latency", cyc, 5 + stall_n);
  endtask

  initial begin
    rstb = 1'b1; start = 1'b0; pc_load = 1'b0; pc_next = '0;
    mem_rdata = '0; mem_valid = 1'b0;
    #3 rstb = 1'b0;
    #1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_instr", instr, 0);
    chk("rst_ivalid", instr_valid, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_misalign", misalign, 0);
    tick(); tick();
    rstb = 1'b1;
    tick();
    chk("rel_busy", busy, 0);
    chk("rel_req", mem_req, 0);

    // Basic fetch from 0. mem_valid stays high in IDLE and must be ignored.
    mem_valid = 1'b1;
    do_fetch(8'h00, 32'h44332211, -1, 0, -1, 8'h00, 8'h00, 8'h04);
    start = 1'b1;                          // start in DONE is ignored
    tick();
    start = 1'b0;
    chk("post_busy", busy, 0);
    chk("post_ivalid", instr_valid, 0);
    chk("post_instr", instr, 32'h44332211);
    chk("post_req", mem_req, 0);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_pc", pc, 8'h04);

    // Three wait cycles on beat 2.
    do_fetch(8'h04, 32'hDEADBEEF, 2, 3, -1, 8'h00, 8'h04, 8'h08);
    tick();

    // IDLE load, then a fetch at the top of the space that wraps the PC.
    pc_load = 1'b1; pc_next = 8'hFC;
    tick();
    pc_load = 1'b0;
    chk("load_idle", pc, 8'hFC);
    do_fetch(8'hFC, 32'h0A0B0C0D, -1, 0, -1, 8'h00, 8'hFC, 8'h00);
    tick();

    // A load together with start redirects the fetch.
    pc_load = 1'b1; pc_next = 8'h20;
    do_fetch(8'h20, 32'h55AA0FF0, -1, 0, -1, 8'h00, 8'h20, 8'h24);
    tick();

    // A load during FETCH becomes pending and replaces the increment.
    do_fetch(8'h24, 32'h01020304, -1, 0, 1, 8'h40, 8'h24, 8'h40);
    tick();

    // A load in DONE applies on the following edge.
    do_fetch(8'h40, 32'h11112222, -1, 0, -1, 8'h00, 8'h40, 8'h44);
    pc_load = 1'b1; pc_next = 8'h60; start = 1'b1;
    tick();
    pc_load = 1'b0; start = 1'b0;
    chk("load_done", pc, 8'h60);
    chk("load_done_busy", busy, 0);
    tick();

    // Misaligned load.
    pc_load = 1'b1; pc_next = 8'h42;
    tick();
    pc_load = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_pc", pc, 8'h40);
    chk("mis_flag", misalign, 1);
    do_fetch(8'h40, 32'hCAFEF00D, -1, 0, -1, 8'h00, 8'h40, 8'h44);
    chk("mis_sticky", misalign, 1);
`else
    chk("mis_pc", pc, 8'h42);
    chk("mis_flag", misalign, 0);
    do_fetch(8'h40, 32'hCAFEF00D, -1, 0, -1, 8'h00, 8'h42, 8'h46);
`endif
    tick();
    pc_load = 1'b1; pc_next = 8'h80;
    tick();
    pc_load = 1'b0;
    chk("aligned_pc", pc, 8'h80);
    chk("aligned_flag", misalign, 0);

    // Reset at beat 2 aborts the fetch immediately.
    start = 1'b1;
    tick();
    start = 1'b0;
    mem_rdata = 8'h99;
    tick();
    mem_rdata = 8'h88;
    tick();
    chk("abort_addr", mem_addr, 8'h82);
    chk("abort_req_pre", mem_req, 1);
    rstb = 1'b0;
    #1;
    chk("abort_req", mem_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ivalid", instr_valid, 0);
    chk("abort_pc", pc, 8'h00);
    chk("abort_instr", instr, 0);
    tick();
    chk("abort_ivalid2", instr_valid, 0);
    rstb = 1'b1;
    tick(); tick();
    chk("abort_rel_busy", busy, 0);
    chk("abort_rel_req", mem_req, 0);
    chk("abort_rel_pc", pc, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
